bit_stream_fifo: RTL and testbench
==================================

# bit_stream_fifo

Parametrised word-in, variable-length-bits-out FIFO for the bitstream front end. Accepts `DIN_W`-bit words and returns the oldest `reqlen` bits (0..`DOUT_W`) per request through a 2-stage registered output. Next generation of the fixed 32-to-15 bit unpacker, adding:
- configurable width and depth
- occupancy, full and empty status
- overflow/underflow protection
- a compile-time scan chain

## Interface
- `DIN_W`, 32, input word width; power of 2.
- `DOUT_W`, 15, max bits per request; must be ≤ `DIN_W`.
- `DEPTH_WORDS`, 32, buffer depth in words; power of 2, ≥ 2.
- `LEN_W`, 4, width of `reqlen`/`lenout`; must satisfy 2^`LEN_W` > `DOUT_W`.
- Derived: `TOT` = `DIN_W`·`DEPTH_WORDS` bits; `CNT_W` = clog2(`TOT`+1).
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pushin`  in  1  write `datain` this cycle.
- `datain`  in  `DIN_W`  word to append; bit 0 is the oldest bit.
- `reqin`  in  1  request `reqlen` bits.
- `reqlen`  in  `LEN_W`  number of bits requested.
- `pushout`  out  1  `dataout`/`lenout` valid.
- `lenout`  out  `LEN_W`  length echoed for the returned data.
- `dataout`  out  `DOUT_W`  returned bits, LSB-first, zero above `lenout`.
- `count`  out  `CNT_W`  occupancy in bits (registered).
- `full`  out  1  `count` > `TOT`−`DIN_W`.
- `empty`  out  1  `count` == 0.
- `ovf`  out  1  one-cycle pulse: push dropped.
- `unf`  out  1  one-cycle pulse: request rejected.
- `scanIn`, `scanEnable` (in, 1) and `scanOut` (out, 1): present only with `BIT_STREAM_FIFO_SCAN_EN`.

## Operation
- Storage: circular bit buffer of `TOT` bits.
  - Word write pointer `wp` is clog2(`DEPTH_WORDS`) bits.
  - Bit read pointer `rp` is clog2(`TOT`) bits.
  - Both wrap naturally modulo their range.
- Push accepted iff `pushin` && !`full` (pre-edge value).
  - Writes `datain` to bits [`wp`·`DIN_W` +: `DIN_W`]; `wp`++.
  - A push while full is dropped; `ovf`=1 next cycle; no state change.
- Request accepted iff `reqin` && `reqlen` ≤ `count` (pre-edge) && `reqlen` ≤ `DOUT_W`.
  - Extracts bits `rp` .. `rp`+`reqlen`−1 modulo `TOT`, so reads wrap across bit `TOT`−1 → 0.
  - `rp` += `reqlen`.
  - Otherwise the request is rejected: `unf`=1 next cycle, no pointer change, no `pushout`.
- `reqlen`=0 is accepted: `pushout`=1, `lenout`=0, `dataout`=0.
- Simultaneous push and request: both evaluated on pre-edge `count`.
  - No same-cycle bypass: a request cannot consume bits pushed in the same cycle.
  - A push while full is not rescued by a same-cycle read.
  - `count` ← `count` + (`DIN_W` if push accepted) − (`reqlen` if request accepted).
- Unused `dataout` bits above `lenout` are always 0.
- `pushout`=0 cycles: `dataout`/`lenout` hold their last values.

## Timing
- Request accepted at edge N → stage-1 register at N → `pushout`/`dataout`/`lenout` at edge N+1, visible in cycle N+1 to N+2. Fixed 2-cycle latency.
- Back-to-back requests give one result per cycle.
- `count`, `full`, `empty`, `ovf`, `unf` update at the same edge as the accepted operation.
- Reset: the following are all 0 one edge after `rst`, and `empty`=1:
  - `pushout`, `lenout`, `dataout`, `count`, `full`, `ovf`, `unf`
  - `wp`, `rp`, both output stages
- Buffer contents are not reset.
- `rst` mid-stream squashes in-flight results: no `pushout` emerges after reset. `rst` overrides `pushin`, `reqin` and `scanEnable`.

## Configuration
- `BIT_STREAM_FIFO_SCAN_EN` defined:
  - Adds ports `scanIn`, `scanEnable`, `scanOut`.
  - While `scanEnable`=1, on every edge, independent of `pushin`, shift the chain `scanIn` → `wp`[0..MSB] → `rp`[0..MSB] → `count`[0..MSB].
  - `scanOut` = `count` MSB (registered). Chain length = 5+10+11 = 26 at defaults.
  - While shifting: pushes and requests are ignored (no `ovf`/`unf`), and `pushout`=0.
- Not defined: ports absent, no scan logic.

## Test plan
- Defaults, empty: push 0xDEADBEEF, then requests 4, 8, 15 on consecutive cycles → `dataout` 0x000F, 0x00EE, 0x6ADB, each 2 cycles after its request; `count` 32 → 28 → 20 → 5.
- Empty: request 1 → `unf` pulse, `pushout` stays 0, `count` 0. Request 0 → `pushout`=1, `lenout`=0, `dataout`=0.
- Full:
  - 32 pushes → `full`=1, `count`=1024.
  - 33rd push → `ovf` pulse, `count` 1024.
  - Push + request 15 in the same cycle → push dropped, `count`=1009.
- Wrap:
  - Fill 32 zero words, consume 1020 bits (68×15).
  - Push 0x0000007F (lands in slot 0) → `count`=36.
  - Request 8 → 0x00F0 (spans bit 1023→0); request 4 → 0x0007.
- `count`=10, push 0xFFFFFFFF + request 10 in the same cycle → returns the 10 old bits, `count`=32.
- `SCAN_EN`:
  - Shift a 26-bit pattern in while `pushin`/`reqin` are toggling, then shift 26 more → the pattern appears on `scanOut` in order.
  - After deassert, `count`/`wp`/`rp` equal the loaded values.

Source files
------------

// File: rtl/bit_stream_fifo_if.sv
// Bus bundle for bit_stream_fifo: push port, request port, registered result and status.
interface bit_stream_fifo_if #(
    parameter int unsigned DIN_W  = 32,
    parameter int unsigned DOUT_W = 15,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned CNT_W  = 11
);
    logic              pushin;
    logic [DIN_W-1:0]  datain;
    logic              reqin;
    logic [LEN_W-1:0]  reqlen;
    logic              pushout;
    logic [LEN_W-1:0]  lenout;
    logic [DOUT_W-1:0] dataout;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;

    modport master (
        output pushin, datain, reqin, reqlen,
        input  pushout, lenout, dataout, count, full, empty, ovf, unf
    );

    modport slave (
        input  pushin, datain, reqin, reqlen,
        output pushout, lenout, dataout, count, full, empty, ovf, unf
    );
endinterface

// File: rtl/bit_stream_fifo.sv
// Word-in, variable-length-bits-out FIFO over a circular bit buffer.
// Results leave through a 2-stage registered output (fixed 2-cycle latency).
// Optional scan chain (wp -> rp -> count) enabled by defining BIT_STREAM_FIFO_SCAN_EN.
module bit_stream_fifo #(
    parameter int unsigned DIN_W       = 32,
    parameter int unsigned DOUT_W      = 15,
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned LEN_W       = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef BIT_STREAM_FIFO_SCAN_EN
    input  logic scanIn,
    input  logic scanEnable,
    output logic scanOut,
`endif
    bit_stream_fifo_if.slave bus
);
    localparam int unsigned TOT   = DIN_W * DEPTH_WORDS;
    localparam int unsigned CNT_W = $clog2(TOT + 1);
    localparam int unsigned WP_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned RP_W  = $clog2(TOT);
    localparam int unsigned OFS_W = $clog2(DIN_W);

    logic [DIN_W-1:0]  mem_q [DEPTH_WORDS];
    logic [WP_W-1:0]   wp_q;
    logic [RP_W-1:0]   rp_q;
    logic [CNT_W-1:0]  count_q;
    logic              s1_valid_q;
    logic [LEN_W-1:0]  s1_len_q;
    logic [DOUT_W-1:0] s1_data_q;
    logic              pushout_q;
    logic [LEN_W-1:0]  lenout_q;
    logic [DOUT_W-1:0] dataout_q;
    logic              ovf_q;
    logic              unf_q;

    logic              full;
    logic              scan_active;
    logic              push_ok;
    logic              req_ok;
    logic [RP_W-1:0]   rd_idx;
    logic [DOUT_W-1:0] rd_bits;

`ifdef BIT_STREAM_FIFO_SCAN_EN
    assign scan_active = scanEnable;
    assign scanOut     = count_q[CNT_W-1];
`else
    assign scan_active = 1'b0;
`endif

    assign full    = count_q > CNT_W'(TOT - DIN_W);
    // Both decisions use the pre-edge count, so a request never sees same-cycle pushed bits.
    assign push_ok = bus.pushin && !full && !scan_active;
    assign req_ok  = bus.reqin && !scan_active && (CNT_W'(bus.reqlen) <= count_q) &&
                     (bus.reqlen <= LEN_W'(DOUT_W));

    // Gather reqlen bits starting at rp; the index wraps naturally at TOT.
    always_comb begin
        rd_bits = '0;
        rd_idx  = '0;
        for (int i = 0; i < DOUT_W; i++) begin
            rd_idx = rp_q + RP_W'(i);
            if (LEN_W'(i) < bus.reqlen) begin
                rd_bits[i] = mem_q[rd_idx[RP_W-1:OFS_W]][rd_idx[OFS_W-1:0]];
            end
        end
    end

    // Buffer storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wp_q] <= bus.datain;
        end
    end

    // Pointers, occupancy, status pulses and the two output stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_len_q   <= '0;
            s1_data_q  <= '0;
            pushout_q  <= 1'b0;
            lenout_q   <= '0;
            dataout_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`ifdef BIT_STREAM_FIFO_SCAN_EN
        end else if (scanEnable) begin
            {count_q, rp_q, wp_q} <= {count_q[CNT_W-2:0], rp_q, wp_q, scanIn};
            s1_valid_q <= 1'b0;
            pushout_q  <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`endif
        end else begin
            ovf_q <= bus.pushin && full;
            unf_q <= bus.reqin && !req_ok;
            if (push_ok) begin
                wp_q <= wp_q + WP_W'(1);
            end
            if (req_ok) begin
                rp_q      <= rp_q + RP_W'(bus.reqlen);
                s1_len_q  <= bus.reqlen;
                s1_data_q <= rd_bits;
            end
            count_q <= count_q + (push_ok ? CNT_W'(DIN_W) : '0)
                               - (req_ok ? CNT_W'(bus.reqlen) : '0);
            s1_valid_q <= req_ok;
            pushout_q  <= s1_valid_q;
            // Result fields hold their last values while no result emerges.
            if (s1_valid_q) begin
                lenout_q  <= s1_len_q;
                dataout_q <= s1_data_q;
            end
        end
    end

    assign bus.pushout = pushout_q;
    assign bus.lenout  = lenout_q;
    assign bus.dataout = dataout_q;
    assign bus.count   = count_q;
    assign bus.full    = full;
    assign bus.empty   = (count_q == '0);
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
endmodule

// File: tb/tb_bit_stream_fifo.sv
// Self-checking bench for bit_stream_fifo: bit-queue reference model plus directed cases.
module tb_bit_stream_fifo;
    localparam int DIN_W       = 32;
    localparam int DOUT_W      = 15;
    localparam int DEPTH_WORDS = 32;
    localparam int LEN_W       = 4;
    localparam int CNT_W       = 11;
    localparam int TOT         = DIN_W * DEPTH_WORDS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scan_in = 1'b0;
    logic scan_en = 1'b0;
    logic scan_out;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    bit_stream_fifo_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    bit_stream_fifo #(
        .DIN_W(DIN_W), .DOUT_W(DOUT_W), .DEPTH_WORDS(DEPTH_WORDS), .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef BIT_STREAM_FIFO_SCAN_EN
        .scanIn(scan_in),
        .scanEnable(scan_en),
        .scanOut(scan_out),
`endif
        .bus(bus)
    );

`ifndef BIT_STREAM_FIFO_SCAN_EN
    assign scan_out = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of bits (oldest first) and a list of results due at a cycle.
    typedef struct {
        int unsigned       due;
        logic [LEN_W-1:0]  len;
        logic [DOUT_W-1:0] data;
    } res_t;

    bit                mq[$];
    res_t              pend[$];
    int unsigned       cyc = 0;
    logic              e_pushout = 1'b0;
    logic [LEN_W-1:0]  e_len = '0;
    logic [DOUT_W-1:0] e_data = '0;
    logic              e_ovf = 1'b0;
    logic              e_unf = 1'b0;
    int                e_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                pend.delete();
                e_pushout = 1'b0;
                e_len = '0;
                e_data = '0;
                e_ovf = 1'b0;
                e_unf = 1'b0;
                e_cnt = 0;
            end else if (!scan_en) begin
                int  sz;
                bit  p_ok;
                bit  r_ok;
                res_t r;
                sz   = mq.size();
                p_ok = bus.pushin && (sz <= TOT - DIN_W);
                r_ok = bus.reqin && (int'(bus.reqlen) <= sz) && (int'(bus.reqlen) <= DOUT_W);
                e_ovf = bus.pushin && !p_ok;
                e_unf = bus.reqin && !r_ok;
                e_pushout = 1'b0;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    r = pend.pop_front();
                    e_pushout = 1'b1;
                    e_len = r.len;
                    e_data = r.data;
                end
                if (r_ok) begin
                    r.due = cyc + 1;
                    r.len = bus.reqlen;
                    r.data = '0;
                    for (int i = 0; i < int'(bus.reqlen); i++) r.data[i] = mq.pop_front();
                    pend.push_back(r);
                end
                if (p_ok) begin
                    for (int i = 0; i < DIN_W; i++) mq.push_back(bus.datain[i]);
                end
                e_cnt = mq.size();
            end
        end
    end

    // Compare every output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("count", 32'(bus.count), 32'(e_cnt));
                chk("full", 32'(bus.full), 32'(e_cnt > TOT - DIN_W));
                chk("empty", 32'(bus.empty), 32'(e_cnt == 0));
                chk("ovf", 32'(bus.ovf), 32'(e_ovf));
                chk("unf", 32'(bus.unf), 32'(e_unf));
                chk("pushout", 32'(bus.pushout), 32'(e_pushout));
                chk("lenout", 32'(bus.lenout), 32'(e_len));
                chk("dataout", 32'(bus.dataout), 32'(e_data));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic p, input logic [31:0] d, input logic r, input int l);
        bus.pushin = p;
        bus.datain = d;
        bus.reqin  = r;
        bus.reqlen = LEN_W'(l);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [25:0] pat;
        logic [25:0] chain;
        drive(1'b0, '0, 1'b0, 0);
        step();
        do_reset();
        check_en = 1'b1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_pushout", 32'(bus.pushout), 32'd0);
        chk("rst_dataout", 32'(bus.dataout), 32'd0);

        // Push one word then three consecutive requests.
        drive(1'b1, 32'hDEADBEEF, 1'b0, 0); step();
        chk("dbf_cnt32", 32'(bus.count), 32'd32);
        drive(1'b0, '0, 1'b1, 4); step();
        chk("dbf_cnt28", 32'(bus.count), 32'd28);
        drive(1'b0, '0, 1'b1, 8); step();
        chk("dbf_cnt20", 32'(bus.count), 32'd20);
        chk("dbf_out4", 32'(bus.dataout), 32'h000F);
        drive(1'b0, '0, 1'b1, 15); step();
        chk("dbf_cnt5", 32'(bus.count), 32'd5);
        chk("dbf_out8", 32'(bus.dataout), 32'h00EE);
        drive(1'b0, '0, 1'b0, 0); step();
        chk("dbf_out15", 32'(bus.dataout), 32'h6ADB);
        chk("dbf_len15", 32'(bus.lenout), 32'd15);
        step();
        chk("dbf_hold", 32'(bus.dataout), 32'h6ADB);

        // Underflow and zero-length request on an empty FIFO.
        do_reset();
        drive(1'b0, '0, 1'b1, 1); step();
        chk("emp_unf", 32'(bus.unf), 32'd1);
        drive(1'b0, '0, 1'b1, 0); step();
        chk("emp_nopush", 32'(bus.pushout), 32'd0);
        drive(1'b0, '0, 1'b0, 0); step();
        chk("zero_pushout", 32'(bus.pushout), 32'd1);
        chk("zero_len", 32'(bus.lenout), 32'd0);

        // Fill, overflow, and a same-cycle push+request while full.
        do_reset();
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            drive(1'b1, $urandom, 1'b0, 0); step();
        end
        chk("full_flag", 32'(bus.full), 32'd1);
        chk("full_cnt", 32'(bus.count), 32'd1024);
        drive(1'b1, $urandom, 1'b0, 0); step();
        chk("ovf_pulse", 32'(bus.ovf), 32'd1);
        chk("ovf_cnt", 32'(bus.count), 32'd1024);
        drive(1'b1, $urandom, 1'b1, 15); step();
        chk("ovf_rd_cnt", 32'(bus.count), 32'd1009);
        drive(1'b0, '0, 1'b0, 0); step(); step();

        // Read that wraps across the end of the bit buffer.
        do_reset();
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            drive(1'b1, '0, 1'b0, 0); step();
        end
        for (int i = 0; i < 68; i++) begin
            drive(1'b0, '0, 1'b1, 15); step();
        end
        drive(1'b1, 32'h0000007F, 1'b0, 0); step();
        chk("wrap_cnt", 32'(bus.count), 32'd36);
        drive(1'b0, '0, 1'b1, 8); step();
        drive(1'b0, '0, 1'b1, 4); step();
        chk("wrap_out8", 32'(bus.dataout), 32'h00F0);
        drive(1'b0, '0, 1'b0, 0); step();
        chk("wrap_out4", 32'(bus.dataout), 32'h0007);

        // Simultaneous push and request at count 10.
        do_reset();
        drive(1'b1, 32'hABCDE123, 1'b0, 0); step();
        drive(1'b0, '0, 1'b1, 15); step();
        drive(1'b0, '0, 1'b1, 7); step();
        chk("sim_cnt10", 32'(bus.count), 32'd10);
        drive(1'b1, 32'hFFFFFFFF, 1'b1, 10); step();
        chk("sim_cnt32", 32'(bus.count), 32'd32);
        drive(1'b0, '0, 1'b0, 0); step();
        chk("sim_out", 32'(bus.dataout), 32'h2AF);
        chk("sim_len", 32'(bus.lenout), 32'd10);

        // Randomized traffic: a push-heavy phase then a drain-heavy phase, with rare resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int pp;
            pp = (i < 2000) ? 40 : 10;
            drive(($urandom_range(99) < pp), $urandom, ($urandom_range(99) < 70),
                  int'($urandom_range(15)));
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;

`ifdef BIT_STREAM_FIFO_SCAN_EN
        // Scan: load a pattern while inputs toggle, then shift it back out.
        check_en = 1'b0;
        pat = 26'($urandom);
        scan_en = 1'b1;
        for (int k = 0; k < 26; k++) begin
            scan_in = pat[k];
            drive(1'($urandom), $urandom, 1'($urandom), int'($urandom_range(15)));
            step();
            chk("scan_pushout", 32'(bus.pushout), 32'd0);
            chk("scan_ovf_unf", 32'({bus.ovf, bus.unf}), 32'd0);
        end
        scan_en = 1'b0;
        drive(1'b0, '0, 1'b0, 0);
        step();
        for (int j = 0; j < 26; j++) chain[j] = pat[25-j];
        chk("scan_wp", 32'(dut.wp_q), 32'(chain[4:0]));
        chk("scan_rp", 32'(dut.rp_q), 32'(chain[14:5]));
        chk("scan_count", 32'(bus.count), 32'(chain[25:15]));
        scan_en = 1'b1;
        for (int k = 0; k < 26; k++) begin
            chk("scan_out", 32'(scan_out), 32'(pat[k]));
            scan_in = 1'b0;
            step();
        end
        scan_en = 1'b0;
        do_reset();
        check_en = 1'b1;
        step();
`endif

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
